// File: rtl/glyph_pixel_pipe.sv
// Glyph-to-pixel generator for VGA text mode: character code, attribute and in-cell
// position become a palette index through a 3-stage pipeline with a registered glyph ROM port.
module glyph_pixel_pipe #(
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int CHAR_BASE    = 32,
  parameter int NUM_GLYPHS   = 96,
  parameter int COLOR_W      = 4,
  parameter int BLINK_FRAMES = 16,
  parameter int CURSOR_ROW   = 14,
  localparam int CW = $clog2(GLYPH_W),
  localparam int RW = $clog2(GLYPH_H),
  localparam int AW = $clog2(NUM_GLYPHS * GLYPH_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         chr_val,
  input  logic [2*COLOR_W:0] attr,
  input  logic [CW-1:0]      col,
  input  logic [RW-1:0]      row,
  input  logic               cursor_here,
  input  logic               cursor_en,
  input  logic               frame_start,
  output logic [AW-1:0]      rom_addr,
  input  logic [GLYPH_W-1:0] rom_data,
  output logic               out_valid,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_fg
);

  // in_valid is a one-way tag with no ready: each request cycle yields exactly one
  // out_valid cycle three clocks later, in order, with no stall and no drop.

  localparam logic [8:0]  IDX_LO     = 9'(CHAR_BASE);
  localparam logic [8:0]  IDX_HI     = 9'(CHAR_BASE + NUM_GLYPHS);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic               valid;
    logic               blank;
    logic               cursor;
    logic [2*COLOR_W:0] attr;
    logic [CW-1:0]      col;
  } stage_t;

  logic [AW-1:0]      rom_addr_q, rom_addr_d;
  stage_t             s1_q, s1_d, s2_q;
  logic               out_valid_q;
  logic [COLOR_W-1:0] pix_color_q, pix_color_d;
  logic               pix_fg_q, pix_fg_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  logic [8:0]         chr9, idx;
  logic               blank_s0;
  logic [GLYPH_W-1:0] shifted;
  logic               glyph_bit, fg_raw;

  always_comb begin
    chr9       = {1'b0, chr_val};
    idx        = chr9 - IDX_LO;
    blank_s0   = (chr9 < IDX_LO) || (chr9 >= IDX_HI) || (32'(row) >= 32'(GLYPH_H));
    rom_addr_d = blank_s0 ? '0 : AW'(32'(idx) * 32'(GLYPH_H) + 32'(row));
    s1_d.valid  = in_valid;
    s1_d.blank  = blank_s0;
    s1_d.cursor = cursor_en && cursor_here && (32'(row) >= 32'(CURSOR_ROW));
    s1_d.attr   = attr;
    s1_d.col    = col;
  end

  // Left shift moves the selected column onto the MSB; columns past the glyph shift out to 0.
  always_comb begin
    shifted     = rom_data << s2_q.col;
    glyph_bit   = shifted[GLYPH_W-1] & ~s2_q.blank;
    fg_raw      = glyph_bit & ~(s2_q.attr[2*COLOR_W] & blink_phase_q);
    pix_fg_d    = s2_q.valid & ((s2_q.cursor & ~blink_phase_q) ? ~fg_raw : fg_raw);
    pix_color_d = '0;
    if (s2_q.valid) begin
      pix_color_d = pix_fg_d ? s2_q.attr[COLOR_W-1:0] : s2_q.attr[2*COLOR_W-1:COLOR_W];
    end
  end

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q    <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      out_valid_q   <= 1'b0;
      pix_color_q   <= '0;
      pix_fg_q      <= 1'b0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      rom_addr_q    <= rom_addr_d;
      s1_q          <= s1_d;
      s2_q          <= s1_q;
      out_valid_q   <= s2_q.valid;
      pix_color_q   <= pix_color_d;
      pix_fg_q      <= pix_fg_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign out_valid = out_valid_q;
  assign pix_color = pix_color_q;
  assign pix_fg    = pix_fg_q;

endmodule

// File: tb/tb_glyph_pixel_pipe.sv
// Directed bench for glyph_pixel_pipe: default geometry with fast blink, a wide-range
// 6x8 variant, and a 12-row variant for out-of-cell rows.
module tb_glyph_pixel_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, p_valid, h_valid;
  logic [7:0]  chr_val;
  logic [8:0]  attr;
  logic [2:0]  col, p_row;
  logic [3:0]  row;
  logic        cursor_here, cursor_en, frame_start;
  logic [10:0] rom_addr, p_addr, h_addr;
  logic [7:0]  rom_data;
  logic [5:0]  p_data;
  logic [7:0]  h_data;
  logic        out_valid, pix_fg, p_ov, p_fg, h_ov, h_fg;
  logic [3:0]  pix_color, p_color, h_color;

  logic [7:0]  rom   [0:2047];
  logic [5:0]  rom_p [0:2047];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [4:0]  exp_q[$];
  int          exp_t_q[$];
  logic [10:0] addr_q[$];
  int          addr_t_q[$];
  logic [4:0]  mon_e;
  int          mon_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  glyph_pixel_pipe #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .chr_val(chr_val), .attr(attr),
    .col(col), .row(row), .cursor_here(cursor_here), .cursor_en(cursor_en),
    .frame_start(frame_start), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .pix_color(pix_color), .pix_fg(pix_fg));

  glyph_pixel_pipe #(.GLYPH_W(6), .GLYPH_H(8), .CHAR_BASE(0), .NUM_GLYPHS(256)) dut_p (
    .clk(clk), .rst(rst), .in_valid(p_valid), .chr_val(chr_val), .attr(attr),
    .col(col), .row(p_row), .cursor_here(cursor_here), .cursor_en(cursor_en),
    .frame_start(frame_start), .rom_addr(p_addr), .rom_data(p_data),
    .out_valid(p_ov), .pix_color(p_color), .pix_fg(p_fg));

  glyph_pixel_pipe #(.GLYPH_H(12), .CURSOR_ROW(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_valid), .chr_val(chr_val), .attr(attr),
    .col(col), .row(row), .cursor_here(cursor_here), .cursor_en(cursor_en),
    .frame_start(frame_start), .rom_addr(h_addr), .rom_data(h_data),
    .out_valid(h_ov), .pix_color(h_color), .pix_fg(h_fg));

  // Synchronous glyph ROMs: data follows the address by one clock.
  assign h_data = 8'hFF;
  always @(posedge clk) begin
    rom_data <= rom[rom_addr];
    p_data   <= rom_p[p_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard for the main instance.
  always @(negedge clk) begin
    if (exp_t_q.size() > 0 && exp_t_q[0] < cyc) begin
      check("missing_out", 32'(0), 32'(1));
      void'(exp_q.pop_front());
      void'(exp_t_q.pop_front());
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(1), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        check("latency", 32'(cyc), 32'(mon_t));
        check("pix_color", 32'(pix_color), 32'(mon_e[4:1]));
        check("pix_fg", 32'(pix_fg), 32'(mon_e[0]));
      end
    end else begin
      check("idle_color", 32'(pix_color), 32'(0));
      check("idle_fg", 32'(pix_fg), 32'(0));
    end
    if (addr_t_q.size() > 0 && addr_t_q[0] == cyc) begin
      check("rom_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
      void'(addr_t_q.pop_front());
    end
  end

  task automatic send(input logic [7:0] ch, input logic [8:0] at, input logic [2:0] c,
                      input logic [3:0] r, input logic cur, input logic fs,
                      input logic [10:0] ea, input logic [3:0] ec, input logic ef);
    @(negedge clk);
    in_valid = 1'b1; chr_val = ch; attr = at; col = c; row = r;
    cursor_en = cur; cursor_here = cur; frame_start = fs;
    exp_q.push_back({ec, ef});
    exp_t_q.push_back(cyc + 3);
    addr_q.push_back(ea);
    addr_t_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; frame_start = 1'b0; cursor_en = 1'b0; cursor_here = 1'b0;
    end
  endtask

  task automatic frame_pulse();
    @(negedge clk);
    in_valid = 1'b0; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // One isolated request to dut_p (use_h=0) or dut_h (use_h=1).
  task automatic send_aux(input logic use_h, input logic [7:0] ch, input logic [2:0] c,
                          input logic [3:0] r, input logic [10:0] ea,
                          input logic [3:0] ec, input logic ef);
    @(negedge clk);
    chr_val = ch; col = c; row = r; p_row = r[2:0]; attr = 9'h01F;
    in_valid = 1'b0; p_valid = ~use_h; h_valid = use_h;
    @(negedge clk);
    p_valid = 1'b0; h_valid = 1'b0;
    check("aux_addr", 32'(use_h ? h_addr : p_addr), 32'(ea));
    @(negedge clk);
    check("aux_early", 32'(use_h ? h_ov : p_ov), 32'(0));
    @(negedge clk);
    check("aux_valid", 32'(use_h ? h_ov : p_ov), 32'(1));
    check("aux_color", 32'(use_h ? h_color : p_color), 32'(ec));
    check("aux_fg", 32'(use_h ? h_fg : p_fg), 32'(ef));
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      rom[i]   = 8'h00;
      rom_p[i] = 6'h00;
    end
    rom[0]       = 8'hFF;
    rom[19]      = 8'h81;
    rom_p[2047]  = 6'b100001;
    rom_p[10'h20A] = 6'b010000;

    rst = 1'b1; in_valid = 1'b0; p_valid = 1'b0; h_valid = 1'b0;
    chr_val = 8'h00; attr = 9'h000; col = 3'd0; row = 4'd0; p_row = 3'd0;
    cursor_here = 1'b0; cursor_en = 1'b0; frame_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_rom_addr", 32'(rom_addr), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_pix_color", 32'(pix_color), 32'(0));
    check("rst_pix_fg", 32'(pix_fg), 32'(0));
    check("rst_p_valid", 32'(p_ov), 32'(0));
    check("rst_h_valid", 32'(h_ov), 32'(0));

    // Glyph row 0x81 across all eight columns, back to back.
    for (int c = 0; c < 8; c++) begin
      send(8'h21, 9'h01F, 3'(c), 4'd3, 1'b0, 1'b0, 11'd19,
           (c == 0 || c == 7) ? 4'hF : 4'h1, (c == 0 || c == 7));
    end
    idle(5);

    // Range edges: below base, past the last glyph, top code, last valid glyph, first glyph.
    send(8'h1F, 9'h01F, 3'd0, 4'd3,  1'b0, 1'b0, 11'd0,     4'h1, 1'b0);
    send(8'h80, 9'h01F, 3'd0, 4'd0,  1'b0, 1'b0, 11'd0,     4'h1, 1'b0);
    send(8'hFF, 9'h01F, 3'd7, 4'd15, 1'b0, 1'b0, 11'd0,     4'h1, 1'b0);
    send(8'h7F, 9'h01F, 3'd0, 4'd15, 1'b0, 1'b0, 11'h5FF,   4'h1, 1'b0);
    send(8'h20, 9'h01F, 3'd3, 4'd0,  1'b0, 1'b0, 11'd0,     4'hF, 1'b1);
    idle(5);

    // Blink with BLINK_FRAMES=2: phase flips after every second frame pulse.
    send(8'h20, 9'h11F, 3'd0, 4'd0, 1'b0, 1'b0, 11'd0, 4'hF, 1'b1);
    idle(4); frame_pulse();
    send(8'h20, 9'h11F, 3'd0, 4'd0, 1'b0, 1'b0, 11'd0, 4'hF, 1'b1);
    idle(4); frame_pulse();
    send(8'h20, 9'h11F, 3'd0, 4'd0, 1'b0, 1'b0, 11'd0, 4'h1, 1'b0);
    send(8'h20, 9'h01F, 3'd0, 4'd0, 1'b0, 1'b0, 11'd0, 4'hF, 1'b1);
    idle(4); frame_pulse();
    send(8'h20, 9'h11F, 3'd0, 4'd0, 1'b0, 1'b0, 11'd0, 4'h1, 1'b0);
    idle(4);
    // Frame pulse coinciding with a request: the toggle reaches that pixel in S2.
    send(8'h20, 9'h11F, 3'd0, 4'd0, 1'b0, 1'b1, 11'd0, 4'hF, 1'b1);
    idle(5);

    // Block cursor over an empty glyph, phase 0 then phase 1.
    send(8'h21, 9'h01F, 3'd2, 4'd14, 1'b1, 1'b0, 11'd30, 4'hF, 1'b1);
    send(8'h21, 9'h01F, 3'd2, 4'd15, 1'b1, 1'b0, 11'd31, 4'hF, 1'b1);
    send(8'h21, 9'h01F, 3'd2, 4'd13, 1'b1, 1'b0, 11'd29, 4'h1, 1'b0);
    idle(5);
    frame_pulse(); frame_pulse();
    send(8'h21, 9'h01F, 3'd2, 4'd14, 1'b1, 1'b0, 11'd30, 4'h1, 1'b0);
    send(8'h21, 9'h01F, 3'd2, 4'd13, 1'b1, 1'b0, 11'd29, 4'h1, 1'b0);
    idle(5);

    // Reset with two pixels in flight, phase 1 and counter at 1; frame_start held during rst.
    frame_pulse();
    send(8'h21, 9'h01F, 3'd0, 4'd3, 1'b0, 1'b0, 11'd19, 4'hF, 1'b1);
    send(8'h21, 9'h01F, 3'd7, 4'd3, 1'b0, 1'b0, 11'd19, 4'hF, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1; frame_start = 1'b1;
    exp_q.delete(); exp_t_q.delete();
    @(negedge clk);
    rst = 1'b0; frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'(0));
      check("post_rst_color", 32'(pix_color), 32'(0));
    end
    send(8'h20, 9'h11F, 3'd0, 4'd0, 1'b0, 1'b0, 11'd0, 4'hF, 1'b1);
    idle(4); frame_pulse();
    send(8'h20, 9'h11F, 3'd0, 4'd0, 1'b0, 1'b0, 11'd0, 4'hF, 1'b1);
    idle(5);

    // 6x8 glyphs over the full code range.
    send_aux(1'b0, 8'hFF, 3'd0, 4'd7, 11'h7FF, 4'hF, 1'b1);
    send_aux(1'b0, 8'hFF, 3'd1, 4'd7, 11'h7FF, 4'h1, 1'b0);
    send_aux(1'b0, 8'hFF, 3'd5, 4'd7, 11'h7FF, 4'hF, 1'b1);
    send_aux(1'b0, 8'hFF, 3'd6, 4'd7, 11'h7FF, 4'h1, 1'b0);
    send_aux(1'b0, 8'hFF, 3'd7, 4'd7, 11'h7FF, 4'h1, 1'b0);
    send_aux(1'b0, 8'h41, 3'd1, 4'd2, 11'h20A, 4'hF, 1'b1);
    send_aux(1'b0, 8'h41, 3'd0, 4'd2, 11'h20A, 4'h1, 1'b0);

    // 12-row cells: rows 12..15 fall outside the glyph and must be blank.
    send_aux(1'b1, 8'h20, 3'd0, 4'd11, 11'd11, 4'hF, 1'b1);
    send_aux(1'b1, 8'h20, 3'd0, 4'd12, 11'd0,  4'h1, 1'b0);
    send_aux(1'b1, 8'h21, 3'd0, 4'd15, 11'd0,  4'h1, 1'b0);
    send_aux(1'b1, 8'h21, 3'd0, 4'd0,  11'd12, 4'hF, 1'b1);

    idle(6);
    check("drain_outputs", 32'(exp_q.size()), 32'(0));
    check("drain_addrs", 32'(addr_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
